priority_grant_fsm: RTL and testbench



---
 rtl/priority_grant_fsm.sv | 141 ++++++++++++++
 tb/tb_priority_grant_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/priority_grant_fsm.sv
// Three-requester arbiter: fixed priority a > b > c, with starvation promotion
// for c, a per-grant hold limit, and a one-cycle GAP between any two grants.
module priority_grant_fsm #(
  parameter int HOLD_MAX   = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       req_c,
  input  logic       done,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LIM   = 8'(HOLD_MAX);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  localparam logic [2:0] GNT_A = 3'b001;
  localparam logic [2:0] GNT_B = 3'b010;
  localparam logic [2:0] GNT_C = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] hold_cnt;

  logic [2:0] req_vec;
  logic       any_req;
  logic       c_promoted;
  logic [2:0] win_gnt;
  logic [1:0] win_id;
  logic       owner_req;
  logic       release_exit;
  logic       hold_hit;

  assign req_vec    = {req_c, req_b, req_a};
  assign any_req    = |req_vec;
  assign c_promoted = req_c && (starve_cnt == STARVE_LIM);

  // Winner selection; promotion of c overrides the fixed a > b > c order.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_gnt = 3'b000;
    win_id  = 2'd0;
    if (c_promoted) begin
      win_gnt = GNT_C;
      win_id  = 2'd3;
    end else if (req_a) begin
      win_gnt = GNT_A;
      win_id  = 2'd1;
    end else if (req_b) begin
      win_gnt = GNT_B;
      win_id  = 2'd2;
    end else if (req_c) begin
      win_gnt = GNT_C;
      win_id  = 2'd3;
    end
  end

  // Exit conditions while holding a grant. A timeout is only flagged when the
  // hold limit is the sole reason for leaving GRANT.
  assign owner_req    = |(gnt & req_vec);
  assign release_exit = done || !owner_req;
  assign hold_hit     = (hold_cnt == HOLD_LIM);

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 3'b000;
      gnt_id     <= 2'd0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      starve_cnt <= 4'd0;
      hold_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (any_req) begin
            state    <= GRANT;
            gnt      <= win_gnt;
            gnt_id   <= win_id;
            busy     <= 1'b1;
            hold_cnt <= 8'd1;
            if (win_gnt == GNT_C) begin
              starve_cnt <= 4'd0;
            end else if (req_c && (starve_cnt != STARVE_LIM)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else begin
            gnt    <= 3'b000;
            gnt_id <= 2'd0;
            busy   <= 1'b0;
          end
        end

        GRANT: begin
          if (release_exit || hold_hit) begin
            state    <= GAP;
            gnt      <= 3'b000;
            gnt_id   <= 2'd0;
            busy     <= 1'b1;
            timeout  <= hold_hit && !release_exit;
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        GAP: begin
          state   <= IDLE;
          gnt     <= 3'b000;
          gnt_id  <= 2'd0;
          busy    <= 1'b0;
          timeout <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          gnt      <= 3'b000;
          gnt_id   <= 2'd0;
          busy     <= 1'b0;
          timeout  <= 1'b0;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_grant_fsm.sv
// Directed bench for priority_grant_fsm: inputs change and outputs are
// sampled on the falling clock edge, each expected value worked out by hand.
module tb_priority_grant_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b, req_c, done;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  priority_grant_fsm #(.HOLD_MAX(8), .STARVE_MAX(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (req_a),
    .req_b  (req_b),
    .req_c  (req_c),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge passes; returns on the following falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; done = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; done = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_gnt",     gnt,            8'h0);
    check("rst_gnt_id",  gnt_id,         8'h0);
    check("rst_busy",    busy,           8'h0);
    check("rst_timeout", timeout,        8'h0);
    check("rst_starve",  dut.starve_cnt, 8'h0);
    check("rst_hold",    dut.hold_cnt,   8'h0);
    rst_n = 1'b1;

    // Idle with no request stays idle
    tick();
    check("idle_gnt",  gnt,  8'h0);
    check("idle_busy", busy, 8'h0);

    // Priority: all three request, a wins; drop a -> GAP, IDLE, then b
    req_a = 1'b1; req_b = 1'b1; req_c = 1'b1;
    tick();
    check("pri_gnt_a",  gnt,    8'h1);
    check("pri_id_a",   gnt_id, 8'h1);
    check("pri_busy_a", busy,   8'h1);
    req_a = 1'b0;
    tick();
    check("pri_gap_gnt",  gnt,     8'h0);
    check("pri_gap_busy", busy,    8'h1);
    check("pri_gap_to",   timeout, 8'h0);
    tick();
    check("pri_idle_gnt",  gnt,  8'h0);
    check("pri_idle_busy", busy, 8'h0);
    tick();
    check("pri_gnt_b", gnt,    8'h2);
    check("pri_id_b",  gnt_id, 8'h2);
    check("pri_starve_after_b", dut.starve_cnt, 8'h2);

    // Done release on the 3rd GRANT cycle of b
    do_reset();
    req_b = 1'b1;
    tick();
    check("done_c1_gnt", gnt, 8'h2);
    done = 1'b1;   // done in IDLE/GAP is ignored; in GRANT it ends the grant
    done = 1'b0;
    tick();
    check("done_c2_gnt", gnt, 8'h2);
    tick();
    check("done_c3_gnt", gnt, 8'h2);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("done_gap_gnt",  gnt,     8'h0);
    check("done_gap_busy", busy,    8'h1);
    check("done_gap_to",   timeout, 8'h0);
    req_b = 1'b0;
    tick();
    check("done_idle_busy", busy, 8'h0);

    // Done asserted in IDLE has no effect on a fresh grant
    done = 1'b1;
    req_c = 1'b1;
    tick();
    done = 1'b0;
    check("idle_done_gnt_c", gnt,    8'h4);
    check("idle_done_id_c",  gnt_id, 8'h3);
    req_c = 1'b0;

    // Timeout: b held for exactly 8 cycles, then GAP with timeout, then b again
    do_reset();
    req_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("to_hold_gnt_%0d", i), gnt,     8'h2);
      check($sformatf("to_hold_to_%0d",  i), timeout, 8'h0);
    end
    tick();
    check("to_gap_gnt",  gnt,     8'h0);
    check("to_gap_to",   timeout, 8'h1);
    check("to_gap_busy", busy,    8'h1);
    tick();
    check("to_idle_to",  timeout, 8'h0);
    check("to_idle_gnt", gnt,     8'h0);
    tick();
    check("to_regrant_b", gnt, 8'h2);
    req_b = 1'b0;

    // Starvation: a wins four times, then c is promoted
    do_reset();
    req_a = 1'b1; req_c = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("starve_gnt_a_%0d", i), gnt, 8'h1);
      check($sformatf("starve_cnt_%0d",   i), dut.starve_cnt, 8'(i));
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check($sformatf("starve_gap_%0d", i), gnt, 8'h0);
      tick();
    end
    tick();
    check("starve_gnt_c",   gnt,            8'h4);
    check("starve_id_c",    gnt_id,         8'h3);
    check("starve_cleared", dut.starve_cnt, 8'h0);

    // No preemption by a while c owns; done coincident with hold limit
    for (int i = 2; i <= 7; i++) begin
      tick();
      check($sformatf("nopre_gnt_%0d", i), gnt, 8'h4);
    end
    tick();
    check("nopre_gnt_8", gnt,          8'h4);
    check("nopre_hold",  dut.hold_cnt, 8'h8);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("coinc_gnt",  gnt,     8'h0);
    check("coinc_to",   timeout, 8'h0);
    check("coinc_busy", busy,    8'h1);
    req_a = 1'b0; req_c = 1'b0;
    tick();

    // Async reset mid-GRANT, between clock edges
    do_reset();
    req_b = 1'b1; req_c = 1'b1;
    tick();
    tick();
    check("arst_pre_gnt",    gnt,            8'h2);
    check("arst_pre_starve", dut.starve_cnt, 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt",    gnt,            8'h0);
    check("arst_id",     gnt_id,         8'h0);
    check("arst_busy",   busy,           8'h0);
    check("arst_to",     timeout,        8'h0);
    check("arst_hold",   dut.hold_cnt,   8'h0);
    check("arst_starve", dut.starve_cnt, 8'h0);
    tick();
    check("arst_held_busy", busy, 8'h0);
    check("arst_held_to",   timeout, 8'h0);
    rst_n = 1'b1;
    req_c = 1'b0;
    tick();
    check("arst_first_arb", gnt, 8'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
